// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute stage.
// Register-file geometry lives in pkg_reg; ALU encodings live in pkg_alu.
package pkg_reg;
   localparam int REG_WIDTH = 64;
   localparam int REG_ADDRW = 8;
   localparam logic [REG_ADDRW-1:0] REG_ZERO = '0;
endpackage

package pkg_alu;
   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SHL,
      ALU_SHR,
      ALU_SAR
   } op_t;

   typedef enum logic {
      ALU_REG,
      ALU_IMM
   } sel_t;

   typedef struct packed {
      logic zf;
      logic cf;
      logic of;
      logic sf;
   } flags_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_B,
      ST_RD_A,
      ST_EXEC,
      ST_WB
   } state_t;

   localparam int SHAMT_W = 6;
endpackage

// File: rtl/alu_exec_if.sv
// Issue handshake and register-file port bundle of the ALU execute stage.
interface alu_exec_if
   import pkg_alu::*;
#(
   parameter int REG_WIDTH = pkg_reg::REG_WIDTH,
   parameter int REG_ADDRW = pkg_reg::REG_ADDRW
);
   logic                 start;
   logic                 ready;
   op_t                  op;
   sel_t                 a_sel;
   logic [REG_ADDRW-1:0] s_reg;
   logic [REG_ADDRW-1:0] b_reg;
   logic [REG_ADDRW-1:0] a_reg;
   logic [REG_WIDTH-1:0] a_imm;
   logic [REG_ADDRW-1:0] rf_raddr;
   logic [REG_WIDTH-1:0] rf_rdata;
   logic                 rf_we;
   logic [REG_ADDRW-1:0] rf_waddr;
   logic [REG_WIDTH-1:0] rf_wdata;
   logic                 done;
   logic                 zf;
   logic                 cf;
   logic                 of;
   logic                 sf;

   modport master (
      output start, op, a_sel, s_reg, b_reg, a_reg, a_imm, rf_rdata,
      input  ready, done, zf, cf, of, sf,
      input  rf_raddr, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  start, op, a_sel, s_reg, b_reg, a_reg, a_imm, rf_rdata,
      output ready, done, zf, cf, of, sf,
      output rf_raddr, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/alu_exec_core.sv
// Combinational ALU: result and status flags from op, b and a.
module alu_core
   import pkg_alu::*;
#(
   parameter int W = pkg_reg::REG_WIDTH
) (
   input  op_t          i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_result,
   output flags_t       o_flags
);
   logic [W:0]         w_sum;
   logic [W:0]         w_dif;
   logic [SHAMT_W-1:0] w_sh;

   assign w_sum = {1'b0, i_b} + {1'b0, i_a};
   assign w_dif = {1'b0, i_b} - {1'b0, i_a};
   assign w_sh  = i_a[SHAMT_W-1:0];

   always_comb begin
      o_result = '0;
      o_flags  = '0;
      case (i_op)
         ALU_ADD: begin
            o_result   = w_sum[W-1:0];
            o_flags.cf = w_sum[W];
            o_flags.of = (i_a[W-1] == i_b[W-1]) &&
                         (w_sum[W-1] != i_b[W-1]);
         end
         ALU_SUB: begin
            o_result   = w_dif[W-1:0];
            o_flags.cf = w_dif[W];
            o_flags.of = (i_a[W-1] != i_b[W-1]) &&
                         (w_dif[W-1] != i_b[W-1]);
         end
         ALU_AND: o_result = i_b & i_a;
         ALU_OR:  o_result = i_b | i_a;
         ALU_XOR: o_result = i_b ^ i_a;
         ALU_SHL: o_result = i_b << w_sh;
         ALU_SHR: o_result = i_b >> w_sh;
         ALU_SAR: o_result = W'($signed(i_b) >>> w_sh);
         default: o_result = '0;
      endcase
      o_flags.zf = (o_result == '0);
      o_flags.sf = o_result[W-1];
   end
endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: read b, read a, execute, write back.
module alu_exec
   import pkg_alu::*;
#(
   parameter int REG_WIDTH = pkg_reg::REG_WIDTH,
   parameter int REG_ADDRW = pkg_reg::REG_ADDRW
) (
   input  logic      clk,
   input  logic      rst,
   alu_exec_if.slave bus
);
   state_t               r_state;
   state_t               w_next;
   op_t                  r_op;
   sel_t                 r_sel;
   logic [REG_ADDRW-1:0] r_s;
   logic [REG_ADDRW-1:0] r_b_reg;
   logic [REG_ADDRW-1:0] r_a_reg;
   logic [REG_WIDTH-1:0] r_imm;
   logic [REG_WIDTH-1:0] r_b;
   logic [REG_WIDTH-1:0] r_res;
   flags_t               r_flags;
   logic [REG_WIDTH-1:0] w_a;
   logic [REG_WIDTH-1:0] w_res;
   flags_t               w_flags;

   // %0 reads as zero whatever the register file returns
   assign w_a = (r_sel == ALU_IMM) ? r_imm :
                (r_a_reg == '0)    ? '0    : bus.rf_rdata;

   alu_core #(.W(REG_WIDTH)) u_core (
      .i_op     (r_op),
      .i_a      (w_a),
      .i_b      (r_b),
      .o_result (w_res),
      .o_flags  (w_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= ALU_ADD;
         r_sel   <= ALU_REG;
         r_s     <= '0;
         r_b_reg <= '0;
         r_a_reg <= '0;
         r_imm   <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: if (bus.start) begin
               r_op    <= bus.op;
               r_sel   <= bus.a_sel;
               r_s     <= bus.s_reg;
               r_b_reg <= bus.b_reg;
               r_a_reg <= bus.a_reg;
               r_imm   <= bus.a_imm;
            end
            ST_RD_A: r_b <= (r_b_reg == '0) ? '0 : bus.rf_rdata;
            ST_EXEC: begin
               r_res   <= w_res;
               r_flags <= w_flags;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next       = r_state;
      bus.ready    = 1'b0;
      bus.done     = 1'b0;
      bus.rf_we    = 1'b0;
      bus.rf_raddr = '0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) w_next = ST_RD_B;
         end
         ST_RD_B: begin
            bus.rf_raddr = r_b_reg;
            w_next       = ST_RD_A;
         end
         ST_RD_A: begin
            if (r_sel == ALU_REG) bus.rf_raddr = r_a_reg;
            w_next = ST_EXEC;
         end
         ST_EXEC: w_next = ST_WB;
         ST_WB: begin
            bus.done     = 1'b1;
            bus.rf_we    = (r_s != '0);
            bus.rf_waddr = r_s;
            bus.rf_wdata = r_res;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign bus.zf = r_flags.zf;
   assign bus.cf = r_flags.cf;
   assign bus.of = r_flags.of;
   assign bus.sf = r_flags.sf;
endmodule

// File: tb/tb_alu_exec.sv
// Randomized scoreboard bench for alu_exec with a behavioural ALU model.
module tb_alu_exec;
   import pkg_alu::*;

   localparam int W  = 64;
   localparam int AW = 8;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic [3:0]    fl;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_exec_if #(.REG_WIDTH(W), .REG_ADDRW(AW)) bus ();

   alu_exec #(.REG_WIDTH(W), .REG_ADDRW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0]  mem [0:255];
   logic          set_req = 1'b0;
   logic [AW-1:0] set_addr = '0;
   logic [W-1:0]  set_data = '0;

   always @(posedge clk) begin
      if (set_req) mem[set_addr] <= set_data;
      if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
      bus.rf_rdata <= mem[bus.rf_raddr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   dones = 0;
   int   issued = 0;
   logic [W-1:0] ref_rf [0:15];
   logic [3:0]   last_fl = 4'h0;

   task automatic check(string name, logic [W-1:0] got, logic [W-1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   function automatic exp_t model(op_t op, logic [W-1:0] b, logic [W-1:0] a);
      exp_t e;
      logic [W-1:0] r;
      logic signed [W+1:0] s;
      logic signed [W+1:0] smax;
      logic signed [W+1:0] smin;
      logic cf, of;
      int   sh;
      smax = 66'sd9223372036854775807;
      smin = -smax - 66'sd1;
      sh = int'(a % 64);
      cf = 1'b0;
      of = 1'b0;
      case (op)
         ALU_ADD: begin
            r  = b + a;
            cf = (r < b);
            s  = $signed({{2{b[W-1]}}, b}) + $signed({{2{a[W-1]}}, a});
            of = (s > smax) || (s < smin);
         end
         ALU_SUB: begin
            r  = b - a;
            cf = (b < a);
            s  = $signed({{2{b[W-1]}}, b}) - $signed({{2{a[W-1]}}, a});
            of = (s > smax) || (s < smin);
         end
         ALU_AND: r = b & a;
         ALU_OR:  r = b | a;
         ALU_XOR: r = b ^ a;
         ALU_SHL: r = b << sh;
         ALU_SHR: r = b >> sh;
         ALU_SAR: begin
            r = b >> sh;
            if (b[W-1])
               for (int i = W - sh; i < W; i++) r[i] = 1'b1;
         end
         default: r = '0;
      endcase
      e.wd  = r;
      e.fl  = {r == '0, cf, of, r[W-1]};
      e.we  = 1'b0;
      e.wa  = '0;
      e.cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.done) begin
            dones++;
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
               e = q.pop_front();
               check("rf_we", W'(bus.rf_we), W'(e.we));
               check("rf_waddr", W'(bus.rf_waddr), W'(e.wa));
               check("rf_wdata", bus.rf_wdata, e.wd);
               check("flags", W'({bus.zf, bus.cf, bus.of, bus.sf}), W'(e.fl));
               check("latency", W'(cyc), W'(e.cyc));
            end
         end else if (bus.rf_we) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_we: got rf_we=1 without done, expected 0");
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!bus.ready && t < 50) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic setreg(int r, logic [W-1:0] v);
      wait_ready();
      set_req  = 1'b1;
      set_addr = AW'(r);
      set_data = v;
      if (r != 0) ref_rf[r] = v;
      @(negedge clk);
      set_req = 1'b0;
   endtask

   task automatic issue(op_t op, sel_t sel, int s, int b, int a,
                        logic [W-1:0] imm, bit jam);
      exp_t e;
      logic [W-1:0] bv, av;
      wait_ready();
      check("ready_idle", W'(bus.ready), W'(1));
      check("flags_hold", W'({bus.zf, bus.cf, bus.of, bus.sf}), W'(last_fl));
      bus.op    = op;
      bus.a_sel = sel;
      bus.s_reg = AW'(s);
      bus.b_reg = AW'(b);
      bus.a_reg = AW'(a);
      bus.a_imm = imm;
      bus.start = 1'b1;
      bv = (b == 0) ? '0 : ref_rf[b];
      av = (sel == ALU_IMM) ? imm : ((a == 0) ? '0 : ref_rf[a]);
      e = model(op, bv, av);
      e.we  = (s != 0);
      e.wa  = AW'(s);
      e.cyc = cyc + 4;
      if (s != 0) ref_rf[s] = e.wd;
      last_fl = e.fl;
      q.push_back(e);
      issued++;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy", W'(bus.ready), W'(0));
      if (jam) begin
         for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            bus.op    = op_t'($urandom_range(0, 7));
            bus.a_sel = sel_t'($urandom_range(0, 1));
            bus.s_reg = AW'($urandom_range(1, 15));
            bus.b_reg = AW'($urandom_range(0, 15));
            bus.a_reg = AW'($urandom_range(0, 15));
            bus.a_imm = {$urandom, $urandom};
            @(negedge clk);
         end
         bus.start = 1'b0;
      end
   endtask

   function automatic logic [W-1:0] rand_imm();
      case ($urandom_range(0, 4))
         0: return 64'h7FFF_FFFF_FFFF_FFFF;
         1: return 64'h8000_0000_0000_0000;
         2: return W'($urandom_range(0, 130));
         3: return '1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int t;
      logic [W-1:0] saved;
      bus.start = 1'b0;
      bus.op    = ALU_ADD;
      bus.a_sel = ALU_REG;
      bus.s_reg = '0;
      bus.b_reg = '0;
      bus.a_reg = '0;
      bus.a_imm = '0;
      for (int i = 0; i < 16; i++) ref_rf[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", W'(bus.ready), W'(1));
      check("rst_done", W'(bus.done), W'(0));
      check("rst_we", W'(bus.rf_we), W'(0));
      check("rst_raddr", W'(bus.rf_raddr), W'(0));
      check("rst_waddr", W'(bus.rf_waddr), W'(0));
      check("rst_wdata", bus.rf_wdata, W'(0));
      check("rst_flags", W'({bus.zf, bus.cf, bus.of, bus.sf}), W'(0));

      setreg(0, 64'hDEAD_BEEF);
      for (int i = 1; i < 16; i++) setreg(i, {$urandom, $urandom});
      setreg(1, 64'd5);
      setreg(2, 64'd7);
      issue(ALU_ADD, ALU_REG, 3, 1, 2, '0, 1'b0);
      issue(ALU_SUB, ALU_IMM, 0, 1, 0, 64'd5, 1'b0);
      setreg(1, 64'd3);
      issue(ALU_SUB, ALU_IMM, 4, 1, 0, 64'd5, 1'b0);
      setreg(1, 64'h7FFF_FFFF_FFFF_FFFF);
      issue(ALU_ADD, ALU_IMM, 5, 1, 0, 64'd1, 1'b0);
      setreg(1, 64'd1);
      issue(ALU_SHL, ALU_IMM, 6, 1, 0, 64'd65, 1'b0);
      issue(ALU_ADD, ALU_IMM, 7, 0, 0, 64'd3, 1'b0);
      issue(ALU_OR, ALU_REG, 8, 0, 0, '0, 1'b0);
      issue(ALU_XOR, ALU_REG, 10, 2, 4, '0, 1'b1);
      issue(ALU_SUB, ALU_IMM, 11, 0, 0, 64'd1, 1'b0);

      saved = ref_rf[9];
      issue(ALU_ADD, ALU_REG, 9, 2, 3, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      void'(q.pop_back());
      issued--;
      ref_rf[9] = saved;
      last_fl = 4'h0;
      @(negedge clk);
      check("abort_ready", W'(bus.ready), W'(1));
      check("abort_flags", W'({bus.zf, bus.cf, bus.of, bus.sf}), W'(0));
      check("abort_done", W'(bus.done), W'(0));
      check("abort_we", W'(bus.rf_we), W'(0));
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0)
            setreg($urandom_range(1, 15), rand_imm());
         issue(op_t'($urandom_range(0, 7)), sel_t'($urandom_range(0, 1)),
               $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), rand_imm(), $urandom_range(0, 7) == 0);
      end

      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("drain", W'(q.size()), W'(0));
      check("done_count", W'(dones), W'(issued));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
